// File: rtl/imm_encode.sv
// rtl/imm_encode.sv - two-stage RISC-V immediate packer with range check and counters
module imm_encode (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] imm,
    input  logic [2:0]  immsrc,
    input  logic [24:0] base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] instr,
    output logic        err,
    output logic [15:0] enc_count,
    output logic [15:0] err_count
);
    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_imm_q, s1_imm_d;
    logic [2:0]  s1_immsrc_q, s1_immsrc_d;
    logic [24:0] s1_base_q, s1_base_d;
    logic        s1_err_q, s1_err_d;
    logic        s2_valid_q, s2_valid_d;
    logic [24:0] s2_instr_q, s2_instr_d;
    logic        s2_err_q, s2_err_d;
    logic [15:0] enc_count_q, enc_count_d;
    logic [15:0] err_count_q, err_count_d;

    logic        s2_load;
    logic        in_accept;
    logic        out_consume;
    logic        in_err;
    logic [24:0] packed_instr;

    assign s2_load     = s1_valid_q & (!s2_valid_q | out_ready);
    assign in_ready    = !s1_valid_q | s2_load;
    assign in_accept   = in_valid & in_ready;
    assign out_consume = s2_valid_q & out_ready;

    // A value fits when every bit above the format's top bit equals the sign bit.
    always_comb begin
        in_err = 1'b0;
        case (immsrc)
            FMT_I, FMT_S: in_err = !((&imm[31:11]) | ~(|imm[31:11]));
            FMT_B:        in_err = imm[0] | !((&imm[31:12]) | ~(|imm[31:12]));
            FMT_J:        in_err = imm[0] | !((&imm[31:20]) | ~(|imm[31:20]));
            FMT_U:        in_err = |imm[11:0];
            default:      in_err = 1'b1;
        endcase
    end

    // Index n of packed_instr corresponds to instruction bit n+7.
    always_comb begin
        packed_instr = s1_base_q;
        case (s1_immsrc_q)
            FMT_I: packed_instr[24:13] = s1_imm_q[11:0];
            FMT_S: begin
                packed_instr[24:18] = s1_imm_q[11:5];
                packed_instr[4:0]   = s1_imm_q[4:0];
            end
            FMT_B: begin
                packed_instr[24]    = s1_imm_q[12];
                packed_instr[23:18] = s1_imm_q[10:5];
                packed_instr[4:1]   = s1_imm_q[4:1];
                packed_instr[0]     = s1_imm_q[11];
            end
            FMT_J: begin
                packed_instr[24]    = s1_imm_q[20];
                packed_instr[23:14] = s1_imm_q[10:1];
                packed_instr[13]    = s1_imm_q[11];
                packed_instr[12:5]  = s1_imm_q[19:12];
            end
            FMT_U:   packed_instr[24:5] = s1_imm_q[31:12];
            default: packed_instr = s1_base_q;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_imm_d    = s1_imm_q;
        s1_immsrc_d = s1_immsrc_q;
        s1_base_d   = s1_base_q;
        s1_err_d    = s1_err_q;
        s2_valid_d  = s2_valid_q;
        s2_instr_d  = s2_instr_q;
        s2_err_d    = s2_err_q;
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;

        if (in_accept) begin
            s1_valid_d  = 1'b1;
            s1_imm_d    = imm;
            s1_immsrc_d = immsrc;
            s1_base_d   = base;
            s1_err_d    = in_err;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_instr_d = packed_instr;
            s2_err_d   = s1_err_q;
        end else if (out_consume) begin
            s2_valid_d = 1'b0;
        end

        if (out_consume) begin
            enc_count_d = enc_count_q + 16'd1;
            if (s2_err_q && (err_count_q != 16'hFFFF)) begin
                err_count_d = err_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_imm_q    <= 32'd0;
            s1_immsrc_q <= 3'd0;
            s1_base_q   <= 25'd0;
            s1_err_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= 25'd0;
            s2_err_q    <= 1'b0;
            enc_count_q <= 16'd0;
            err_count_q <= 16'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_imm_q    <= s1_imm_d;
            s1_immsrc_q <= s1_immsrc_d;
            s1_base_q   <= s1_base_d;
            s1_err_q    <= s1_err_d;
            s2_valid_q  <= s2_valid_d;
            s2_instr_q  <= s2_instr_d;
            s2_err_q    <= s2_err_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign instr     = s2_instr_q;
    assign err       = s2_err_q;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_imm_encode.sv
// tb/tb_imm_encode.sv - directed and round-trip checks for imm_encode
module tb_imm_encode;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] imm;
    logic [2:0]  immsrc;
    logic [24:0] base;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] instr;
    logic        err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imm_encode dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .immsrc    (immsrc),
        .base      (base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .err       (err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sign/zero extension of a packed instruction back to the immediate.
    function automatic logic [31:0] decode(input logic [24:0] ins, input logic [2:0] src);
        logic [31:0] w;
        w = {ins, 7'b0};
        case (src)
            3'd0:    decode = {{20{w[31]}}, w[31:20]};
            3'd1:    decode = {{20{w[31]}}, w[31:25], w[11:7]};
            3'd2:    decode = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd3:    decode = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: decode = {w[31:12], 12'b0};
        endcase
    endfunction

    // One request through an idle pipeline with out_ready held high.
    task automatic xfer(input logic [31:0] i_imm, input logic [2:0] i_src, input logic [24:0] i_base,
                        output logic [24:0] o_instr, output logic o_err);
        in_valid  = 1'b1;
        imm       = i_imm;
        immsrc    = i_src;
        base      = i_base;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat_early", {31'd0, out_valid}, 32'd0);
        step();
        chk("lat_two", {31'd0, out_valid}, 32'd1);
        o_instr = instr;
        o_err   = err;
        step();
    endtask

    initial begin
        logic [24:0] oi;
        logic        oe;
        logic [31:0] r;
        logic [31:0] rimm;
        logic [2:0]  rsrc;
        logic [24:0] q[$];
        int          sent;
        int          got;
        int          c;
        logic        acc;
        logic        con;
        logic        seen;
        logic [31:0] k;

        reset = 1'b1; in_valid = 1'b0; imm = '0; immsrc = '0; base = '0; out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_instr", {7'd0, instr}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_enc", {16'd0, enc_count}, 32'd0);
        chk("rst_errc", {16'd0, err_count}, 32'd0);
        reset = 1'b0;
        step();

        xfer(32'hFFFFF800, 3'd0, 25'h0, oi, oe);
        chk("I_neg_instr", {7'd0, oi}, 32'h1000000); chk("I_neg_err", {31'd0, oe}, 32'd0);
        xfer(32'h00000FFE, 3'd2, 25'h1FFFFFF, oi, oe);
        chk("B_instr", {7'd0, oi}, 32'h0FFFFFF); chk("B_err", {31'd0, oe}, 32'd0);
        xfer(32'h00001000, 3'd2, 25'h0, oi, oe);
        chk("B_ovf_instr", {7'd0, oi}, 32'h1000000); chk("B_ovf_err", {31'd0, oe}, 32'd1);
        xfer(32'h00000001, 3'd3, 25'h0, oi, oe);
        chk("J_odd_instr", {7'd0, oi}, 32'h0); chk("J_odd_err", {31'd0, oe}, 32'd1);
        xfer(32'h12345000, 3'd4, 25'h0, oi, oe);
        chk("U_instr", {7'd0, oi}, 32'h02468A0); chk("U_err", {31'd0, oe}, 32'd0);
        xfer(32'hFFFFFFFF, 3'd1, 25'h0, oi, oe);
        chk("S_m1_instr", {7'd0, oi}, 32'h1FC001F); chk("S_m1_err", {31'd0, oe}, 32'd0);
        xfer(32'h00000800, 3'd1, 25'h0, oi, oe);
        chk("S_ovf_instr", {7'd0, oi}, 32'h1000000); chk("S_ovf_err", {31'd0, oe}, 32'd1);
        xfer(32'h00000000, 3'd5, 25'h0ABCDEF, oi, oe);
        chk("undef_instr", {7'd0, oi}, 32'h0ABCDEF); chk("undef_err", {31'd0, oe}, 32'd1);
        xfer(32'h00000123, 3'd0, 25'h1FFFFFF, oi, oe);
        chk("I_base_instr", {7'd0, oi}, 32'h0247FFF); chk("I_base_err", {31'd0, oe}, 32'd0);
        xfer(32'h12345001, 3'd4, 25'h0, oi, oe);
        chk("U_low_err", {31'd0, oe}, 32'd1);
        xfer(32'h000FFFFE, 3'd3, 25'h0, oi, oe);
        chk("J_max_instr", {7'd0, oi}, 32'h0FFFFE0); chk("J_max_err", {31'd0, oe}, 32'd0);
        xfer(32'hFFFFF000, 3'd2, 25'h0, oi, oe);
        chk("B_min_instr", {7'd0, oi}, 32'h1000000); chk("B_min_err", {31'd0, oe}, 32'd0);
        chk("dir_enc_count", {16'd0, enc_count}, 32'd12);
        chk("dir_err_count", {16'd0, err_count}, 32'd5);

        for (int i = 0; i < 40; i++) begin
            rsrc = 3'(i % 5);
            r = $urandom;
            case (rsrc)
                3'd0, 3'd1: rimm = {{20{r[11]}}, r[11:0]};
                3'd2:       rimm = {{19{r[12]}}, r[12:1], 1'b0};
                3'd3:       rimm = {{11{r[20]}}, r[20:1], 1'b0};
                default:    rimm = {r[31:12], 12'b0};
            endcase
            xfer(rimm, rsrc, 25'($urandom), oi, oe);
            chk("rt_err", {31'd0, oe}, 32'd0);
            chk("rt_value", decode(oi, rsrc), rimm);
        end

        sent = 0; got = 0; q.delete();
        for (c = 0; c < 60; c++) begin
            out_ready = (c >= 5);
            in_valid  = (sent < 6);
            imm       = 32'(sent + 1);
            immsrc    = 3'd0;
            base      = 25'd0;
            #1;
            if (c == 2) chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            if (c >= 2 && c <= 4) begin
                chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_hold_instr", {7'd0, instr}, 32'h0002000);
            end
            acc = in_valid & in_ready;
            con = out_valid & out_ready;
            if (con) begin
                if (q.size() == 0) chk("bp_dup", 32'd1, {31'd0, con} - 32'd1);
                else chk("bp_order", {7'd0, instr}, {7'd0, q.pop_front()});
                got++;
            end
            if (acc) begin
                q.push_back({imm[11:0], 13'd0});
                sent++;
            end
            step();
            if (got == 6) break;
        end
        in_valid = 1'b0;
        chk("bp_count", 32'(got), 32'd6);
        step(); step();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0;
        in_valid = 1'b1; imm = 32'h5; immsrc = 3'd0; step();
        imm = 32'h6; step();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1; imm = 32'h7; step();
        reset = 1'b0; in_valid = 1'b0;
        chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_enc", {16'd0, enc_count}, 32'd0);
        chk("mid_errc", {16'd0, err_count}, 32'd0);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | out_valid;
        end
        chk("mid_nothing_out", {31'd0, seen}, 32'd0);

        sent = 0; got = 0;
        immsrc = 3'd7; imm = 32'd0; base = 25'd0; out_ready = 1'b1;
        for (k = 0; k < 32'd70000; k++) begin
            in_valid = (sent < 65536);
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got++;
            step();
            if (got == 65536) break;
        end
        in_valid = 1'b0;
        chk("wrap_got", 32'(got), 32'd65536);
        chk("wrap_enc", {16'd0, enc_count}, 32'd0);
        chk("sat_errc", {16'd0, err_count}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imm_encode.md
IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  request present.
REQ-004 SHALL have port: in_ready  output  1  request accepted when in_valid&in_ready at clk edge.
REQ-005 SHALL have port: imm  input  32  immediate value to pack.
REQ-006 SHALL have port: immsrc  input  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101-111 undefined.
REQ-007 SHALL have port: base  input  25  instruction bits [31:7]; non-immediate fields (rd, rs1, rs2, funct) are taken from here.
REQ-008 SHALL have port: out_valid  output  1  result present.
REQ-009 SHALL have port: out_ready  input  1  result consumed when out_valid&out_ready at clk edge.
REQ-010 SHALL have port: instr  output  25  packed instruction bits [31:7].
REQ-011 SHALL have port: err  output  1  imm not representable in immsrc format, or immsrc undefined; qualified by out_valid.
REQ-012 SHALL have port: enc_count  output  16  number of results consumed; wraps at 16'hFFFF.
REQ-013 SHALL have port: err_count  output  16  number of results consumed with err=1; saturates at 16'hFFFF.

Function
REQ-014 SHALL be a two-stage pipeline. S1 registers imm/immsrc/base and computes err. S2 holds the merged instr and err.
REQ-015 SHALL accept-to-out_valid latency of exactly 2 cycles when there is no backpressure. Throughput SHALL be 1 per cycle.
REQ-016 SHALL compute s2_load = s1_valid & (!s2_valid | out_ready).
REQ-017 SHALL drive in_ready = !s1_valid | s2_load, combinationally, with no dependence on in_valid.
REQ-018 SHALL hold instr, err and out_valid stable while out_valid=1 and out_ready=0. SHALL accept no new request while both stages are full and stalled.
REQ-019 SHALL, for format I, place imm[11:0] into instr[31:20].
REQ-020 SHALL, for format S, place imm[11:5] into instr[31:25] and imm[4:0] into instr[11:7].
REQ-021 SHALL, for format B, place imm[12] into [31], imm[10:5] into [30:25], imm[4:1] into [11:8] and imm[11] into [7].
REQ-022 SHALL, for format J, place imm[20] into [31], imm[10:1] into [30:21], imm[11] into [20] and imm[19:12] into [19:12].
REQ-023 SHALL, for format U, place imm[31:12] into instr[31:12].
REQ-024 SHALL copy all instr bits not named for the format from base.
REQ-025 SHALL, for an undefined immsrc, pass instr = base unchanged.
REQ-026 SHALL set err for format I or S when imm[31:11] is not all-equal.
REQ-027 SHALL set err for format B when imm[0]=1 or imm[31:12] is not all-equal.
REQ-028 SHALL set err for format J when imm[0]=1 or imm[31:20] is not all-equal.
REQ-029 SHALL set err for format U when imm[11:0]!=0.
REQ-030 SHALL set err for any undefined immsrc. On err, the packing of REQ-019..025 SHALL still be applied using the truncated bits.
REQ-031 SHALL guarantee that, when err=0, sign/zero extension of instr per immsrc reproduces imm exactly.
REQ-032 SHALL increment enc_count and, if err=1, err_count on each out_valid&out_ready cycle only.

Reset
REQ-033 SHALL, while reset=1 at a clk edge, clear s1_valid, s2_valid, enc_count and err_count, and set instr=0 and err=0.
REQ-034 SHALL hold out_valid=0 in the cycle after reset. in_ready SHALL be 1 in that cycle.
REQ-035 SHALL discard any in-flight request when reset is asserted mid-operation. Nothing SHALL be emitted for it after reset.
REQ-036 SHALL ignore in_valid in any cycle in which reset=1.

Verification
REQ-037 SHALL pass: I, imm=32'hFFFFF800, base=0 -> 2 cycles later instr[31:20]=12'h800, all other bits 0, err=0.
REQ-038 SHALL pass: B, imm=32'h00000FFE, base=25'h1FFFFFF -> instr[31]=0, [30:25]=6'h3F, [11:8]=4'hF, [7]=1, other bits 1, err=0. B, imm=32'h00001000 -> err=1.
REQ-039 SHALL pass: J, imm=32'h00000001 -> err=1, err_count increments on consume. U, imm=32'h12345000 -> instr[31:12]=20'h12345, err=0.
REQ-040 SHALL pass: back-to-back stream with out_ready held 0 for 3 cycles -> in_ready=0 after 2 accepts, out data stable, no loss or duplication after release.
REQ-041 SHALL pass: reset asserted with both stages full -> next cycle out_valid=0, counts=0, in_ready=1.
REQ-042 SHALL pass: random imm/immsrc round-trip -> extending instr per immsrc equals imm whenever err=0. After 65536 consumes, enc_count wraps to 0.
